// File: rtl/reg_file_param.sv
`default_nettype none
// ============================================================================
//  Module     : reg_file_param
//  Description: Parameterised register file with two combinational read
//               ports (write bypass), one write port, and a multiply-result
//               register whose halves are written back to a register pair
//               over two cycles.
//  Revision   : 1.0 - initial release
// ============================================================================
module reg_file_param #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int AW       = $clog2(DEPTH),
  parameter int ZERO_REG = 0
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic [AW-1:0]      RS,
  input  logic [AW-1:0]      RT,
  input  logic [AW-1:0]      RD,
  input  logic [WIDTH-1:0]   WriteData,
  input  logic               RegWrite,
  input  logic               MulRegWrite,
  input  logic [2*WIDTH-1:0] MulResult,
  output logic [WIDTH-1:0]   ReadRS,
  output logic [WIDTH-1:0]   ReadRT,
  output logic [WIDTH-1:0]   MulHi,
  output logic [WIDTH-1:0]   MulLo,
  output logic               Busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WB_LO = 2'd1,
    WB_HI = 2'd2
  } state_t;

  localparam logic [AW-1:0] c_idxOne  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] c_idxZero = '0;

  state_t             r_state;
  state_t             w_stateNext;
  logic [2*WIDTH-1:0] r_mulReg;
  logic [AW-1:0]      r_base;
  logic [AW-1:0]      w_baseInc;
  logic [WIDTH-1:0]   r_regs [DEPTH];

  logic               w_wrReq;
  logic               w_wrEn;
  logic [AW-1:0]      w_wrIdx;
  logic [WIDTH-1:0]   w_wrData;
  logic               w_mulAccept;

  // High half of the pair goes to the next index, wrapping modulo DEPTH
  assign w_baseInc = r_base + c_idxOne;

  // Next-state and write-port selection; strobes are only honoured in IDLE
  always_comb begin
    w_stateNext = r_state;
    w_wrReq     = 1'b0;
    w_wrIdx     = RD;
    w_wrData    = WriteData;
    w_mulAccept = 1'b0;
    case (r_state)
      IDLE: begin
        if (RegWrite) begin
          w_wrReq  = 1'b1;
          w_wrIdx  = RD;
          w_wrData = WriteData;
        end
        if (MulRegWrite) begin
          w_mulAccept = 1'b1;
          w_stateNext = WB_LO;
        end
      end
      WB_LO: begin
        w_wrReq     = 1'b1;
        w_wrIdx     = r_base;
        w_wrData    = r_mulReg[WIDTH-1:0];
        w_stateNext = WB_HI;
      end
      WB_HI: begin
        w_wrReq     = 1'b1;
        w_wrIdx     = w_baseInc;
        w_wrData    = r_mulReg[2*WIDTH-1:WIDTH];
        w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // A write commits only outside reset and never to a hardwired zero register
  assign w_wrEn = w_wrReq && Reset_n && !((ZERO_REG != 0) && (w_wrIdx == c_idxZero));

  // FSM state, multiply register and captured base index
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      r_state  <= IDLE;
      r_mulReg <= '0;
      r_base   <= '0;
    end else begin
      r_state <= w_stateNext;
      if (w_mulAccept) begin
        r_mulReg <= MulResult;
        r_base   <= RD;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_regs
      // One storage word per index, written when the commit targets it
      always_ff @(posedge Clock) begin
        if (!Reset_n) begin
          r_regs[gi] <= '0;
        end else if (w_wrEn && (w_wrIdx == AW'(gi))) begin
          r_regs[gi] <= w_wrData;
        end
      end
    end
  endgenerate

  // Read with bypass of the word being committed this cycle
  function automatic logic [WIDTH-1:0] readPort(input logic [AW-1:0] idx);
    logic [WIDTH-1:0] val;
    if ((ZERO_REG != 0) && (idx == c_idxZero)) begin
      val = '0;
    end else if (w_wrEn && (w_wrIdx == idx)) begin
      val = w_wrData;
    end else begin
      val = r_regs[idx];
    end
    return val;
  endfunction

  // Port A read
  always_comb begin
    ReadRS = readPort(RS);
  end

  // Port B read
  always_comb begin
    ReadRT = readPort(RT);
  end

  assign MulHi = r_mulReg[2*WIDTH-1:WIDTH];
  assign MulLo = r_mulReg[WIDTH-1:0];
  assign Busy  = (r_state == WB_LO) || (r_state == WB_HI);

endmodule
`default_nettype wire

// File: tb/tb_reg_file_param.sv
`default_nettype none
// ============================================================================
//  Module     : tb_reg_file_param
//  Description: Directed self-checking bench for reg_file_param; two
//               instances (ZERO_REG=0 and ZERO_REG=1) share all inputs.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_reg_file_param;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic               Clock;
  logic               Reset_n;
  logic [AW-1:0]      RS, RT, RD;
  logic [WIDTH-1:0]   WriteData;
  logic               RegWrite, MulRegWrite;
  logic [2*WIDTH-1:0] MulResult;

  logic [WIDTH-1:0]   ReadRS0, ReadRT0, MulHi0, MulLo0;
  logic               Busy0;
  logic [WIDTH-1:0]   ReadRS1, ReadRT1, MulHi1, MulLo1;
  logic               Busy1;

  int errCount   = 0;
  int checkCount = 0;

  reg_file_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(0)) dut0 (
    .Clock(Clock), .Reset_n(Reset_n), .RS(RS), .RT(RT), .RD(RD),
    .WriteData(WriteData), .RegWrite(RegWrite), .MulRegWrite(MulRegWrite),
    .MulResult(MulResult), .ReadRS(ReadRS0), .ReadRT(ReadRT0),
    .MulHi(MulHi0), .MulLo(MulLo0), .Busy(Busy0)
  );

  reg_file_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1)) dut1 (
    .Clock(Clock), .Reset_n(Reset_n), .RS(RS), .RT(RT), .RD(RD),
    .WriteData(WriteData), .RegWrite(RegWrite), .MulRegWrite(MulRegWrite),
    .MulResult(MulResult), .ReadRS(ReadRS1), .ReadRT(ReadRT1),
    .MulHi(MulHi1), .MulLo(MulLo1), .Busy(Busy1)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past a rising edge and settle before driving/sampling
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    Reset_n = 1'b0; RS = '0; RT = '0; RD = '0; WriteData = '0;
    RegWrite = 1'b0; MulRegWrite = 1'b0; MulResult = '0;
    tick(); tick();
    Reset_n = 1'b1;
    #1;
    checkVal("rst_rs",   32'(ReadRS0), 32'h0);
    checkVal("rst_rt",   32'(ReadRT0), 32'h0);
    checkVal("rst_mulhi", 32'(MulHi0), 32'h0);
    checkVal("rst_mullo", 32'(MulLo0), 32'h0);
    checkVal("rst_busy", 32'(Busy0),   32'h0);

    // Single write with same-cycle bypass on both ports
    RD = 3'd3; WriteData = 16'h1234; RegWrite = 1'b1; RS = 3'd3; RT = 3'd3;
    #1;
    checkVal("byp_rs", 32'(ReadRS0), 32'h1234);
    checkVal("byp_rt", 32'(ReadRT0), 32'h1234);
    tick();
    RegWrite = 1'b0;
    #1;
    checkVal("wr_reg3", 32'(ReadRS0), 32'h1234);

    // Multiply pair writeback at base 2
    RD = 3'd2; MulResult = 32'hDEADBEEF; MulRegWrite = 1'b1;
    tick();
    MulRegWrite = 1'b0; RS = 3'd2; RT = 3'd3;
    #1;
    checkVal("mul_hi",   32'(MulHi0), 32'hDEAD);
    checkVal("mul_lo",   32'(MulLo0), 32'hBEEF);
    checkVal("busy_lo",  32'(Busy0),  32'h1);
    checkVal("wblo_byp", 32'(ReadRS0), 32'hBEEF);
    checkVal("wblo_rt",  32'(ReadRT0), 32'h1234);
    tick();
    #1;
    checkVal("busy_hi",  32'(Busy0),   32'h1);
    checkVal("reg2_lo",  32'(ReadRS0), 32'hBEEF);
    checkVal("wbhi_byp", 32'(ReadRT0), 32'hDEAD);
    tick();
    #1;
    checkVal("busy_done", 32'(Busy0),   32'h0);
    checkVal("reg3_hi",   32'(ReadRT0), 32'hDEAD);

    // Index wrap from base DEPTH-1 into register 0
    RD = 3'd7; MulResult = 32'h00010002; MulRegWrite = 1'b1;
    tick();
    MulRegWrite = 1'b0; RS = 3'd0; RT = 3'd7;
    tick();
    #1;
    checkVal("wrap_byp_z0", 32'(ReadRS0), 32'h0001);
    checkVal("wrap_byp_z1", 32'(ReadRS1), 32'h0000);
    tick();
    #1;
    checkVal("wrap_reg7",    32'(ReadRT0), 32'h0002);
    checkVal("wrap_reg0_z0", 32'(ReadRS0), 32'h0001);
    checkVal("wrap_reg0_z1", 32'(ReadRS1), 32'h0000);
    checkVal("wrap_reg7_z1", 32'(ReadRT1), 32'h0002);

    // Strobes during writeback are ignored
    RD = 3'd4; MulResult = 32'hAAAABBBB; MulRegWrite = 1'b1;
    tick();
    RD = 3'd6; WriteData = 16'h5555; RegWrite = 1'b1; MulResult = 32'h11112222;
    tick();
    #1;
    checkVal("ign_mulhi", 32'(MulHi0), 32'hAAAA);
    tick();
    RegWrite = 1'b0; MulRegWrite = 1'b0; RS = 3'd4; RT = 3'd6;
    #1;
    checkVal("ign_busy", 32'(Busy0),   32'h0);
    checkVal("ign_reg4", 32'(ReadRS0), 32'hBBBB);
    checkVal("ign_reg6", 32'(ReadRT0), 32'h0000);
    RS = 3'd5;
    #1;
    checkVal("ign_reg5", 32'(ReadRS0), 32'hAAAA);

    // Both strobes in IDLE: plain write, then overwritten by low half
    RD = 3'd1; WriteData = 16'h7777; MulResult = 32'h33334444;
    RegWrite = 1'b1; MulRegWrite = 1'b1; RS = 3'd1; RT = 3'd2;
    tick();
    RegWrite = 1'b0; MulRegWrite = 1'b0;
    #1;
    checkVal("both_wr", 32'(ReadRT0), 32'hBEEF);
    RT = 3'd1;
    #1;
    checkVal("both_first", 32'(ReadRT0), 32'h4444);
    tick();
    tick();
    RT = 3'd2;
    #1;
    checkVal("both_reg1", 32'(ReadRS0), 32'h4444);
    checkVal("both_reg2", 32'(ReadRT0), 32'h3333);

    // Direct write to index 0 under both ZERO_REG settings
    RD = 3'd0; WriteData = 16'hFFFF; RegWrite = 1'b1; RS = 3'd0;
    #1;
    checkVal("z_byp_z0", 32'(ReadRS0), 32'hFFFF);
    checkVal("z_byp_z1", 32'(ReadRS1), 32'h0000);
    tick();
    RegWrite = 1'b0;
    #1;
    checkVal("z_reg_z1", 32'(ReadRS1), 32'h0000);

    // Reset in WB_LO aborts the writeback; reset also beats a write strobe
    RD = 3'd5; MulResult = 32'h99998888; MulRegWrite = 1'b1;
    tick();
    MulRegWrite = 1'b0; Reset_n = 1'b0;
    RD = 3'd3; WriteData = 16'hABCD; RegWrite = 1'b1;
    tick();
    Reset_n = 1'b1; RegWrite = 1'b0;
    tick(); tick();
    RS = 3'd5; RT = 3'd6;
    #1;
    checkVal("abort_busy",  32'(Busy0),   32'h0);
    checkVal("abort_reg5",  32'(ReadRS0), 32'h0000);
    checkVal("abort_reg6",  32'(ReadRT0), 32'h0000);
    checkVal("abort_mulhi", 32'(MulHi0),  32'h0000);
    RS = 3'd3; RT = 3'd0;
    #1;
    checkVal("abort_reg3",  32'(ReadRS0), 32'h0000);
    checkVal("abort_reg0",  32'(ReadRT0), 32'h0000);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
`default_nettype wire
